fetch_queue_top: RTL and testbench

//  Parametrised fetch stage: owns the PC, reads instr (combinational imem read at PCounterF) and pushes
//  {PC, instr, PC+4} into a DEPTH-entry prefetch queue feeding decode. Decouples fetch from decode stalls.

---
 rtl/fetch_queue_top.sv | 118 +++++++++++
 tb/tb_fetch_queue_top.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_top.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
// Holds the fetch PC, captures {PC, instr, PC+4} on push, and presents the queue head to decode.
module fetch_queue_top #(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCSrc,
    input  logic [ADDR_WIDTH-1:0]         PCTarget,
    input  logic                          stallF,
    input  logic                          stallD,
    input  logic                          flushD,
    input  logic [DATA_WIDTH-1:0]         instr,
    output logic [ADDR_WIDTH-1:0]         PCounterF,
    output logic [DATA_WIDTH-1:0]         InstrD,
    output logic [ADDR_WIDTH-1:0]         PCounterD,
    output logic [ADDR_WIDTH-1:0]         PCPlus4D,
    output logic                          ValidD,
    output logic [$clog2(DEPTH+1)-1:0]    FillLevel
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] pc4_mem_r   [DEPTH];

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      fill_r;

    logic                  valid_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  clear_s;
    logic [ADDR_WIDTH-1:0] pc_plus4_s;

    assign valid_s    = (fill_r != CNT_W'(0));
    assign full_s     = (fill_r == CNT_W'(DEPTH));
    assign pop_s      = valid_s & ~stallD;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign push_s     = ~stallF & ~PCSrc & ~flushD & (~full_s | pop_s);
    assign clear_s    = PCSrc | flushD;
    assign pc_plus4_s = pc_r + ADDR_WIDTH'(4);

    // Fetch PC, queue pointers and fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r   <= RESET_PC;
            head_r <= PTR_W'(0);
            tail_r <= PTR_W'(0);
            fill_r <= CNT_W'(0);
        end else begin
            if (PCSrc) begin
                pc_r <= PCTarget;
            end else if (push_s) begin
                pc_r <= pc_plus4_s;
            end else begin
                pc_r <= pc_r;
            end

            if (clear_s) begin
                head_r <= PTR_W'(0);
                tail_r <= PTR_W'(0);
                fill_r <= CNT_W'(0);
            end else begin
                if (push_s) begin
                    tail_r <= tail_r + PTR_W'(1);
                end
                if (pop_s) begin
                    head_r <= head_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   fill_r <= fill_r + CNT_W'(1);
                    2'b01:   fill_r <= fill_r - CNT_W'(1);
                    default: fill_r <= fill_r;
                endcase
            end
        end
    end

    // Queue storage: entries need no reset because fill level gates their visibility.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            pc_mem_r[tail_r]    <= pc_r;
            instr_mem_r[tail_r] <= instr;
            pc4_mem_r[tail_r]   <= pc_plus4_s;
        end
    end

    // Decode-side view of the head entry, neutral values when empty.
    always_comb begin
        InstrD    = NOP_INSTR;
        PCounterD = '0;
        PCPlus4D  = '0;
        if (valid_s) begin
            InstrD    = instr_mem_r[head_r];
            PCounterD = pc_mem_r[head_r];
            PCPlus4D  = pc4_mem_r[head_r];
        end else begin
            InstrD    = NOP_INSTR;
            PCounterD = '0;
            PCPlus4D  = '0;
        end
    end

    assign PCounterF = pc_r;
    assign ValidD    = valid_s;
    assign FillLevel = fill_r;

endmodule

// File: tb/tb_fetch_queue_top.sv
// Directed bench for fetch_queue_top: stimulus queues expected decode entries,
// a negedge monitor checks each entry as decode consumes it.
module tb_fetch_queue_top;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc, stallF, stallD, flushD;
    logic [31:0] PCTarget;
    logic [31:0] instr;
    logic [31:0] PCounterF, InstrD, PCounterD, PCPlus4D;
    logic        ValidD;
    logic [2:0]  FillLevel;

    logic        b_stallF;
    logic [15:0] b_PCounterF, b_PCounterD, b_PCPlus4D;
    logic [31:0] b_instr, b_InstrD;
    logic        b_ValidD;
    logic [1:0]  b_FillLevel;

    entry_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    assign instr   = imem(PCounterF);
    assign b_instr = imem({16'h0000, b_PCounterF});

    fetch_queue_top #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4),
                      .RESET_PC(32'h00000100), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .instr(instr),
        .PCounterF(PCounterF), .InstrD(InstrD), .PCounterD(PCounterD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FillLevel(FillLevel)
    );

    fetch_queue_top #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(2),
                      .RESET_PC(16'hFFFC), .NOP_INSTR(32'h00000013)) dut_b (
        .clk(clk), .rst(rst), .PCSrc(1'b0), .PCTarget(16'h0000),
        .stallF(b_stallF), .stallD(1'b1), .flushD(1'b0), .instr(b_instr),
        .PCounterF(b_PCounterF), .InstrD(b_InstrD), .PCounterD(b_PCounterD),
        .PCPlus4D(b_PCPlus4D), .ValidD(b_ValidD), .FillLevel(b_FillLevel)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_push(input logic [31:0] pc);
        entry_t e;
        e.pc  = pc;
        e.ins = imem(pc);
        e.pc4 = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whenever decode consumes the head, compare it with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ValidD && !stallD) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {32'h0, PCounterD}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("pop_pc",    {32'h0, PCounterD}, {32'h0, e.pc});
                chk("pop_instr", {32'h0, InstrD},    {32'h0, e.ins});
                chk("pop_pc4",   {32'h0, PCPlus4D},  {32'h0, e.pc4});
            end
        end
    end

    initial begin
        rst = 1'b1; PCSrc = 1'b0; PCTarget = 32'h0; stallF = 1'b0;
        stallD = 1'b1; flushD = 1'b0; b_stallF = 1'b0;
        cyc(); cyc();
        chk("rst_fill",  FillLevel, 3'd0);
        chk("rst_valid", ValidD,    1'b0);
        chk("rst_instr", InstrD,    32'h00000013);
        chk("rst_pcd",   PCounterD, 32'h0);
        chk("rst_pc4d",  PCPlus4D,  32'h0);
        chk("rst_pcf",   PCounterF, 32'h00000100);
        rst = 1'b0;

        // Fill while decode stalls; the 16-bit instance pushes its wrap entry on the first edge.
        for (int i = 0; i < 4; i++) begin
            exp_push(32'h100 + 32'(4 * i));
            cyc();
            if (i == 0) begin
                b_stallF = 1'b1;
                chk("wrap_pcf",   b_PCounterF, 16'h0000);
                chk("wrap_pcd",   b_PCounterD, 16'hFFFC);
                chk("wrap_pc4d",  b_PCPlus4D,  16'h0000);
                chk("wrap_valid", b_ValidD,    1'b1);
                chk("wrap_instr", b_InstrD,    imem(32'h0000FFFC));
            end
        end
        chk("full_fill",  FillLevel, 3'd4);
        chk("full_pcf",   PCounterF, 32'h110);
        chk("full_valid", ValidD,    1'b1);
        chk("full_pcd",   PCounterD, 32'h100);
        cyc();
        chk("full_hold_pcf",  PCounterF, 32'h110);
        chk("full_hold_fill", FillLevel, 3'd4);

        // Full with decode flowing: one pop and one push per edge.
        stallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_push(32'h110 + 32'(4 * i));
            cyc();
            chk("stream_fill", FillLevel, 3'd4);
        end
        chk("stream_pcf", PCounterF, 32'h120);

        // Drop to three entries, then redirect while fetch is also stalled.
        stallF = 1'b1;
        cyc();
        chk("three_fill", FillLevel, 3'd3);
        stallD = 1'b1; PCSrc = 1'b1; PCTarget = 32'h2000;
        cyc();
        exp_q.delete();
        chk("redir_fill",  FillLevel, 3'd0);
        chk("redir_valid", ValidD,    1'b0);
        chk("redir_instr", InstrD,    32'h00000013);
        chk("redir_pcf",   PCounterF, 32'h2000);
        PCSrc = 1'b0; stallF = 1'b0;
        exp_push(32'h2000);
        cyc();
        chk("redir_pcd", PCounterD, 32'h2000);

        // Flush alone with two entries: queue empties, PC does not move.
        exp_push(32'h2004);
        cyc();
        chk("pre_flush_fill", FillLevel, 3'd2);
        flushD = 1'b1;
        cyc();
        exp_q.delete();
        chk("flush_fill",  FillLevel, 3'd0);
        chk("flush_valid", ValidD,    1'b0);
        chk("flush_pcf",   PCounterF, 32'h2008);
        flushD = 1'b0; stallD = 1'b0;
        exp_push(32'h2008);
        cyc();
        stallF = 1'b1;
        cyc();
        chk("drain_fill", FillLevel, 3'd0);

        // Reset with the queue half full and a redirect pending: reset wins.
        stallF = 1'b0; stallD = 1'b1;
        exp_push(32'h200C);
        exp_push(32'h2010);
        cyc(); cyc();
        chk("half_fill", FillLevel, 3'd2);
        rst = 1'b1; PCSrc = 1'b1; PCTarget = 32'h3000;
        cyc();
        exp_q.delete();
        chk("rst2_pcf",   PCounterF, 32'h00000100);
        chk("rst2_fill",  FillLevel, 3'd0);
        chk("rst2_valid", ValidD,    1'b0);
        chk("rst2_instr", InstrD,    32'h00000013);
        chk("rst2_pcd",   PCounterD, 32'h0);
        chk("rst2_pc4d",  PCPlus4D,  32'h0);
        rst = 1'b0; PCSrc = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
